// File: rtl/run_det_pkg.sv
// run_det_pkg: state encoding and output-mode constants for run_detector_moore
package run_det_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  localparam int MODE_LEVEL        = 0;
  localparam int MODE_PULSE_ONCE   = 1;
  localparam int MODE_PULSE_REPEAT = 2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (inc && q != '1) q <= q + W'(1);
  end
endmodule

// File: rtl/run_detector_moore.sv
// run_detector_moore: Moore detector for runs of RUN_LEN valid 1s with level/pulse/repeat output modes
module run_detector_moore
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int MODE = 0,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clear,
  output logic             out,
  output logic [LW-1:0]    run_cnt,
  output logic [CNT_W-1:0] match_cnt
);
  if (RUN_LEN < 1 || MODE > MODE_PULSE_REPEAT || MODE < MODE_LEVEL) begin : g_bad_param
    $error("run_detector_moore: illegal RUN_LEN or MODE");
  end
  localparam logic [LW-1:0] FULL = LW'(RUN_LEN);
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [1:0] S_FIRST = (RUN_LEN == 1) ? S_HIT : S_RUN;
  localparam bit REP = (MODE == MODE_PULSE_REPEAT);
  logic [1:0] state, nxt_state;
  logic [LW-1:0] cnt, nxt_cnt;
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    if (in_valid && !in) begin
      nxt_state = S_IDLE;
      nxt_cnt = '0;
    end else if (in_valid) begin
      if (state == S_IDLE || (state == S_HIT && REP)) begin
        nxt_state = S_FIRST;
        nxt_cnt = ONE;
      end else if (state == S_RUN) begin
        nxt_cnt = cnt + ONE;
        nxt_state = (cnt + ONE == FULL) ? S_HIT : S_RUN;
      end else begin
        nxt_state = S_HOLD;
      end
    end else if (state == S_HIT) begin
      nxt_state = REP ? S_IDLE : S_HOLD;
      nxt_cnt = REP ? '0 : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
    end
  end
  assign out = (MODE == MODE_LEVEL) ? (state == S_HIT || state == S_HOLD) : (state == S_HIT);
  assign run_cnt = cnt;
  sat_counter #(.W(CNT_W)) u_match (
    .clk(clk),
    .reset(reset),
    .clr(clear),
    .inc(nxt_state == S_HIT),
    .q(match_cnt)
  );
endmodule

// File: tb/tb_run_detector_moore.sv
// tb_run_detector_moore: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_run_detector_moore;
  logic clk = 1'b0;
  logic reset = 1'b1, in_valid = 1'b0, din = 1'b0, clear = 1'b0;
  logic o0, o1, o2, o3;
  logic [1:0] rc0, rc1, rc2;
  logic [0:0] rc3;
  logic [7:0] mc0, mc1, mc2;
  logic [1:0] mc3;
  logic       o_a [4];
  logic [3:0] rc_a[4];
  logic [7:0] mc_a[4];
  typedef struct {
    int    d;
    string nm;
    logic  eo;
    int    erc;
    int    emc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  run_detector_moore #(.RUN_LEN(2), .MODE(0), .CNT_W(8)) d0 (.clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .clear(clear), .out(o0), .run_cnt(rc0), .match_cnt(mc0));
  run_detector_moore #(.RUN_LEN(3), .MODE(1), .CNT_W(8)) d1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .clear(clear), .out(o1), .run_cnt(rc1), .match_cnt(mc1));
  run_detector_moore #(.RUN_LEN(3), .MODE(2), .CNT_W(8)) d2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .clear(clear), .out(o2), .run_cnt(rc2), .match_cnt(mc2));
  run_detector_moore #(.RUN_LEN(1), .MODE(2), .CNT_W(2)) d3 (.clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .clear(clear), .out(o3), .run_cnt(rc3), .match_cnt(mc3));
  always_comb begin
    o_a[0] = o0;
    o_a[1] = o1;
    o_a[2] = o2;
    o_a[3] = o3;
    rc_a[0] = {2'b0, rc0};
    rc_a[1] = {2'b0, rc1};
    rc_a[2] = {2'b0, rc2};
    rc_a[3] = {3'b0, rc3};
    mc_a[0] = mc0;
    mc_a[1] = mc1;
    mc_a[2] = mc2;
    mc_a[3] = {6'b0, mc3};
  end
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      if (o_a[e.d] !== e.eo || rc_a[e.d] !== 4'(e.erc) || mc_a[e.d] !== 8'(e.emc)) begin
        n_err++;
        $display("FAIL %s (d%0d): out=%b run_cnt=%0d match_cnt=%0d, expected out=%b run_cnt=%0d match_cnt=%0d",
                 e.nm, e.d, o_a[e.d], rc_a[e.d], mc_a[e.d], e.eo, e.erc, e.emc);
      end
    end
  end
  task automatic step(input int d, input string nm, input logic v, input logic i, input logic c,
                      input logic r, input logic eo, input int erc, input int emc);
    in_valid = v;
    din = i;
    clear = c;
    reset = r;
    @(posedge clk);
    sb.push_back('{d, nm, eo, erc, emc});
    #1;
  endtask
  task automatic rst(input int d, input string nm);
    step(d, nm, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask
  initial begin
    rst(0, "t1 reset");
    step(0, "t1 in0", 1, 0, 0, 0, 0, 0, 0);
    step(0, "t1 1st 1", 1, 1, 0, 0, 0, 1, 0);
    step(0, "t1 hit", 1, 1, 0, 0, 1, 2, 1);
    step(0, "t1 hold", 1, 1, 0, 0, 1, 2, 1);
    step(0, "t1 fall", 1, 0, 0, 0, 0, 0, 1);
    step(0, "t1 clear", 1, 0, 1, 0, 0, 0, 0);
    rst(1, "t2 reset");
    step(1, "t2 1", 1, 1, 0, 0, 0, 1, 0);
    step(1, "t2 2", 1, 1, 0, 0, 0, 2, 0);
    step(1, "t2 pulse", 1, 1, 0, 0, 1, 3, 1);
    for (int k = 0; k < 4; k++) step(1, "t2 sticky", 1, 1, 0, 0, 0, 3, 1);
    step(1, "t2 fall", 1, 0, 0, 0, 0, 0, 1);
    rst(2, "t3 reset");
    for (int k = 0; k < 9; k++) step(2, "t3 repeat", 1, 1, 0, 0, k % 3 == 2, k % 3 + 1, (k + 1) / 3);
    step(2, "t3 stall after hit", 0, 1, 0, 0, 0, 0, 3);
    rst(1, "t4 reset");
    step(1, "t4 1", 1, 1, 0, 0, 0, 1, 0);
    step(1, "t4 2", 1, 1, 0, 0, 0, 2, 0);
    for (int k = 0; k < 4; k++) step(1, "t4 stall", 0, 0, 0, 0, 0, 2, 0);
    step(1, "t4 hit", 1, 1, 0, 0, 1, 3, 1);
    step(1, "t4 stall after hit", 0, 1, 0, 0, 0, 3, 1);
    step(1, "t4 fall", 1, 0, 0, 0, 0, 0, 1);
    rst(3, "t5 reset");
    step(3, "t5 hit1", 1, 1, 0, 0, 1, 1, 1);
    step(3, "t5 hit2", 1, 1, 0, 0, 1, 1, 2);
    for (int k = 0; k < 4; k++) step(3, "t5 saturate", 1, 1, 0, 0, 1, 1, 3);
    step(3, "t5 clear on hit", 1, 1, 1, 0, 1, 1, 0);
    step(3, "t5 after clear", 1, 1, 0, 0, 1, 1, 1);
    step(3, "t5 stall after hit", 0, 0, 0, 0, 0, 0, 1);
    rst(0, "t6 reset");
    step(0, "t6 run1", 1, 1, 0, 0, 0, 1, 0);
    step(0, "t6 reset mid-run", 1, 1, 0, 1, 0, 0, 0);
    step(0, "t6 restart", 1, 1, 0, 0, 0, 1, 0);
    rst(2, "t6b reset");
    step(2, "t6b 1", 1, 1, 0, 0, 0, 1, 0);
    step(2, "t6b 2", 1, 1, 0, 0, 0, 2, 0);
    step(2, "t6b pulse", 1, 1, 0, 0, 1, 3, 1);
    step(2, "t6b reset mid-pulse", 1, 1, 0, 1, 0, 0, 0);
    step(2, "t6b restart", 1, 1, 0, 0, 0, 1, 0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
